// File: rtl/ram_pkg.sv
// Shared definitions for the dual-port RAM: write-mode constants and FSM state encoding.
package ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return pipeline for one RAM port: LATENCY (1 or 2) data/valid register stages.
module ram_rd_pipe #(
    parameter int DATA_W  = 8,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vld_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_p1_q;
    logic [DATA_W-1:0] data_p1_q;

    // Stage 1: capture the read word; data only moves on a valid request so the output holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            data_p1_q <= '0;
        end else begin
            vld_p1_q <= vld_i;
            if (vld_i) begin
                data_p1_q <= data_i;
            end
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic              vld_p2_q;
            logic [DATA_W-1:0] data_p2_q;

            // Stage 2
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p2_q  <= 1'b0;
                    data_p2_q <= '0;
                end else begin
                    vld_p2_q <= vld_p1_q;
                    if (vld_p1_q) begin
                        data_p2_q <= data_p1_q;
                    end
                end
            end

            assign vld_o  = vld_p2_q;
            assign data_o = data_p2_q;
        end else begin : g_lat1
            assign vld_o  = vld_p1_q;
            assign data_o = data_p1_q;
        end
    endgenerate

endmodule

// File: rtl/param_dual_port_ram.sv
// True dual-port RAM with optional post-reset clear sweep, selectable read latency and write mode.
module param_dual_port_ram
    import ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 6,
    parameter int READ_LATENCY   = 1,
    parameter int WRITE_MODE     = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_write_enable,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic [DATA_W-1:0] a_read,
    output logic              a_valid,
    input  logic              b_en,
    input  logic              b_write_enable,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic [DATA_W-1:0] b_read,
    output logic              b_valid,
    output logic              busy,
    output logic              collision
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              collision_q, collision_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              clr_wr;
    logic              a_acc, b_acc, a_wr, b_wr;
    logic              a_port_we;
    logic [ADDR_W-1:0] a_port_wa;
    logic [DATA_W-1:0] a_port_wd;
    logic [DATA_W-1:0] a_rd_word, b_rd_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            clr_cnt_q   <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            collision_q <= collision_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_wr    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                clr_wr    = ~rst;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    state_d = ST_RUN;
                end
            end
            default: ;
        endcase
    end

    assign busy  = (state_q == ST_CLEAR);
    assign a_acc = a_en & ~busy & ~rst;
    assign b_acc = b_en & ~busy & ~rst;
    assign a_wr  = a_acc & a_write_enable;
    assign b_wr  = b_acc & b_write_enable;

    assign collision_d = a_acc & b_acc & (a_addr == b_addr) & (a_write_enable | b_write_enable);
    assign collision   = collision_q;

    // The clear sweep borrows port A's write path so the array keeps two write ports.
    assign a_port_we = clr_wr | a_wr;
    assign a_port_wa = busy ? clr_cnt_q : a_addr;
    assign a_port_wd = busy ? '0 : a_data;

    // Port A is written last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (b_wr) begin
            mem_q[b_addr] <= b_data;
        end
        if (a_port_we) begin
            mem_q[a_port_wa] <= a_port_wd;
        end
    end

    // Cross-port reads always see the pre-edge word; only the writing port can bypass.
    assign a_rd_word = (WRITE_MODE == WRITE_FIRST && a_wr) ? a_data : mem_q[a_addr];
    assign b_rd_word = (WRITE_MODE == WRITE_FIRST && b_wr) ? b_data : mem_q[b_addr];

    ram_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (a_acc),
        .data_i (a_rd_word),
        .vld_o  (a_valid),
        .data_o (a_read)
    );

    ram_rd_pipe #(.DATA_W(DATA_W), .LATENCY(READ_LATENCY)) u_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .vld_i  (b_acc),
        .data_i (b_rd_word),
        .vld_o  (b_valid),
        .data_o (b_read)
    );

endmodule
